// File: rtl/led_cursor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Purpose  : Shared types and LED pattern action helpers for led_cursor_ctrl.
//            Patterns are carried in a fixed-width container (pat_t) and the
//            real pattern width is passed as an argument, so one set of
//            helpers serves every NUM_LEDS up to c_MAX_LEDS.
// Contents : state_t, pat_t, classify(), apply_action() and its helpers.
// Revision : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RIGHT = 2'b01,
    ST_LEFT  = 2'b10,
    ST_BOTH  = 2'b11
  } state_t;

  // Widest pattern the helpers can handle.
  localparam int c_MAX_LEDS = 64;
  typedef logic [c_MAX_LEDS-1:0] pat_t;

  // The encoding is chosen so that {left, right} maps directly onto state_t.
  function automatic state_t classify(input logic left, input logic right);
    return state_t'({left, right});
  endfunction

  function automatic pat_t width_mask(input int n);
    pat_t m;
    m = '0;
    for (int i = 0; i < c_MAX_LEDS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic pat_t rotate_up(input pat_t v, input int n);
    return ((v << 1) | (v >> (n - 1))) & width_mask(n);
  endfunction

  function automatic pat_t rotate_down(input pat_t v, input int n);
    return ((v >> 1) | (v << (n - 1))) & width_mask(n);
  endfunction

  // Shift toward the MSB unless the top LED is already lit.
  function automatic pat_t shift_up_sat(input pat_t v, input int n);
    pat_t top;
    top = v >> (n - 1);
    return top[0] ? v : ((v << 1) & width_mask(n));
  endfunction

  // Shift toward the LSB unless the bottom LED is already lit.
  function automatic pat_t shift_down_sat(input pat_t v);
    return v[0] ? v : (v >> 1);
  endfunction

  // Each lit bit lights both neighbours; the end bits fall off, no wrap.
  function automatic pat_t spread(input pat_t v, input int n);
    return ((v << 1) | (v >> 1)) & width_mask(n);
  endfunction

  function automatic pat_t apply_action(input state_t cls, input pat_t v,
                                        input int n, input logic wrap);
    case (cls)
      ST_LEFT:  return wrap ? rotate_up(v, n)   : shift_up_sat(v, n);
      ST_RIGHT: return wrap ? rotate_down(v, n) : shift_down_sat(v);
      ST_BOTH:  return spread(v, n);
      default:  return v;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_cursor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_cursor_if
// Purpose  : Pad / LED bundle between the bongo decoder side and the cursor
//            controller.
// Signals  : left_in, right_in (async pad levels), clear (sync restore),
//            leds (pattern), step_pulse (new-value strobe), state (last press).
// Modports : master - pad/clear source, LED sink; slave - the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface led_cursor_if import led_ctrl_pkg::*; #(
  parameter int NUM_LEDS = 10
) ();

  logic                left_in;
  logic                right_in;
  logic                clear;
  logic [NUM_LEDS-1:0] leds;
  logic                step_pulse;
  state_t              state;

  modport master (
    output left_in, right_in, clear,
    input  leds, step_pulse, state
  );

  modport slave (
    input  left_in, right_in, clear,
    output leds, step_pulse, state
  );

endinterface
`default_nettype wire

// File: rtl/led_cursor_ctrl_tick.sv
`default_nettype none
// ============================================================================
// Module   : sample_tick_gen
// Purpose  : Free-running 0..DIV-1 counter; tick is high for the one cycle
//            the counter sits at DIV-1. clr restarts the count from 0.
// Ports    : clk, rst_n (async active-low), clr (sync restart), tick (out).
// Revision : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
  parameter int DIV = 400000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int              c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

  logic [c_CW-1:0] r_cnt;

  // With DIV=1 the counter is pinned at 0 and tick is permanently high.
  assign tick = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_cnt <= '0;
    else if (clr || tick) r_cnt <= '0;
    else                  r_cnt <= r_cnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/led_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_cursor_ctrl
// Purpose  : Samples synchronised left/right pad levels on a divided tick,
//            classifies each sample and moves an NUM_LEDS-bit LED pattern
//            (rotate / saturating shift / spread), with hold-to-repeat.
// Ports    : clk, rst_n (async active-low), bus (led_cursor_if.slave):
//            left_in, right_in, clear in; leds, step_pulse, state out.
// Revision : 1.0 - initial release
// ============================================================================
module led_cursor_ctrl import led_ctrl_pkg::*; #(
  parameter int NUM_LEDS     = 10,
  parameter int INIT_POS     = 5,
  parameter int TICK_DIV     = 400000,
  parameter int REPEAT_TICKS = 0,
  parameter int WRAP         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  led_cursor_if.slave bus
);

  localparam int                  c_HW        = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic [c_HW-1:0]     c_HOLD_LAST = c_HW'(REPEAT_TICKS - 1);
  localparam logic [NUM_LEDS-1:0] c_INIT      = {{(NUM_LEDS-1){1'b0}}, 1'b1} << INIT_POS;

  logic r_left_meta, r_left_sync;
  logic r_right_meta, r_right_sync;

  logic                r_step;
  logic [NUM_LEDS-1:0] r_leds;
  logic [c_HW-1:0]     r_hold;
  state_t              r_state;

  logic                w_tick;
  logic                w_act;
  logic                w_step_nxt;
  logic [NUM_LEDS-1:0] w_leds_nxt;
  logic [NUM_LEDS-1:0] w_leds_new;
  logic [c_HW-1:0]     w_hold_nxt;
  state_t              w_state_nxt;
  state_t              w_cls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left_meta  <= 1'b0;
      r_left_sync  <= 1'b0;
      r_right_meta <= 1'b0;
      r_right_sync <= 1'b0;
    end else begin
      r_left_meta  <= bus.left_in;
      r_left_sync  <= r_left_meta;
      r_right_meta <= bus.right_in;
      r_right_sync <= r_right_meta;
    end
  end

  sample_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clear),
    .tick  (w_tick)
  );

  assign w_cls      = classify(r_left_sync, r_right_sync);
  assign w_leds_new = NUM_LEDS'(apply_action(w_cls, pat_t'(r_leds), NUM_LEDS, WRAP != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_leds  <= c_INIT;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_leds  <= w_leds_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_leds_nxt  = r_leds;
    w_step_nxt  = 1'b0;
    w_act       = 1'b0;

    if (bus.clear) begin
      // Clear wins over a coinciding tick.
      w_state_nxt = ST_IDLE;
      w_hold_nxt  = '0;
      w_leds_nxt  = c_INIT;
    end else if (w_tick) begin
      if (w_cls == ST_IDLE) begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
      end else if (w_cls != r_state) begin
        // Any change to a non-idle class acts at once, including direct
        // LEFT<->RIGHT<->BOTH transitions.
        w_act       = 1'b1;
        w_state_nxt = w_cls;
        w_hold_nxt  = '0;
      end else if (REPEAT_TICKS != 0) begin
        if (r_hold == c_HOLD_LAST) begin
          w_act      = 1'b1;
          w_hold_nxt = '0;
        end else begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
    end

    if (w_act) begin
      w_leds_nxt = w_leds_new;
      // A saturated shift leaves the pattern alone and must not strobe.
      w_step_nxt = (w_leds_new != r_leds);
    end
  end

  assign bus.leds       = r_leds;
  assign bus.step_pulse = r_step;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_led_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_cursor_ctrl
// Purpose  : Self-checking bench for led_cursor_ctrl. Three instances:
//            rotate (WRAP=1), saturate (WRAP=0) and repeat (REPEAT_TICKS=3).
//            Stimulus pushes expected {leds,state} per step into a queue per
//            instance; a negedge monitor pops on every step_pulse.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_cursor_ctrl;
  import led_ctrl_pkg::*;

  localparam int NL = 10;
  localparam int TD = 4;
  localparam logic [NL-1:0] c_RST = 10'b0000100000;

  typedef logic [NL+1:0] exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  led_cursor_if #(.NUM_LEDS(NL)) if_w ();
  led_cursor_if #(.NUM_LEDS(NL)) if_s ();
  led_cursor_if #(.NUM_LEDS(NL)) if_r ();

  led_cursor_ctrl #(.NUM_LEDS(NL), .INIT_POS(5), .TICK_DIV(TD), .REPEAT_TICKS(0), .WRAP(1))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w));
  led_cursor_ctrl #(.NUM_LEDS(NL), .INIT_POS(5), .TICK_DIV(TD), .REPEAT_TICKS(0), .WRAP(0))
    u_sat  (.clk(clk), .rst_n(rst_n), .bus(if_s));
  led_cursor_ctrl #(.NUM_LEDS(NL), .INIT_POS(5), .TICK_DIV(TD), .REPEAT_TICKS(3), .WRAP(1))
    u_rep  (.clk(clk), .rst_n(rst_n), .bus(if_r));

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$], q1[$], q2[$];
  int   rep_t[8];
  int   rep_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int u);
    case (u)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int u, input logic [NL-1:0] l, input state_t s);
    case (u)
      0:       q0.push_back({l, s});
      1:       q1.push_back({l, s});
      default: q2.push_back({l, s});
    endcase
  endtask

  task automatic mon(input int u, input logic [NL-1:0] l, input logic [1:0] s);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    case (u)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      tests++;
      fails++;
      $display("FAIL unexpected_step_u%0d: got step with leds %b state %b, required no step", u, l, s);
    end else begin
      check($sformatf("step_u%0d_leds_state", u), 32'({l, s}), 32'(e));
    end
    if (u == 2 && rep_n < 8) begin
      rep_t[rep_n] = cyc;
      rep_n++;
    end
  endtask

  always @(negedge clk) begin
    if (if_w.step_pulse) mon(0, if_w.leds, if_w.state);
    if (if_s.step_pulse) mon(1, if_s.leds, if_s.state);
    if (if_r.step_pulse) mon(2, if_r.leds, if_r.state);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pads(input int u, input logic l, input logic r);
    case (u)
      0:       begin if_w.left_in = l; if_w.right_in = r; end
      1:       begin if_s.left_in = l; if_s.right_in = r; end
      default: begin if_r.left_in = l; if_r.right_in = r; end
    endcase
  endtask

  task automatic press(input int u, input logic l, input logic r);
    set_pads(u, l, r);
    wait_cyc(4 * TD);
    set_pads(u, 1'b0, 1'b0);
    wait_cyc(3 * TD);
  endtask

  task automatic drain(input int u, input int budget, input string name);
    for (int i = 0; i < budget && qsize(u) != 0; i++) wait_cyc(1);
    check(name, 32'(qsize(u)), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_leds_w"}, 32'(if_w.leds), 32'(c_RST));
    check({tag, "_leds_s"}, 32'(if_s.leds), 32'(c_RST));
    check({tag, "_leds_r"}, 32'(if_r.leds), 32'(c_RST));
    check({tag, "_state"},  32'({if_w.state, if_s.state, if_r.state}), 32'd0);
    check({tag, "_step"},   32'({if_w.step_pulse, if_s.step_pulse, if_r.step_pulse}), 32'd0);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) set_pads(u, 1'b0, 1'b0);
    if_w.clear = 1'b0;
    if_s.clear = 1'b0;
    if_r.clear = 1'b0;

    // Reset values
    rst_n = 1'b0;
    wait_cyc(3);
    chk_reset("reset");
    rst_n = 1'b1;
    wait_cyc(2);

    // Rotate: long hold gives one step only
    push(0, 10'b0001000000, ST_LEFT);
    set_pads(0, 1'b1, 1'b0);
    wait_cyc(20 * TD);
    check("hold_one_step_leds", 32'(if_w.leds), 32'(10'b0001000000));
    check("hold_one_step_q", 32'(qsize(0)), 32'd0);
    set_pads(0, 1'b0, 1'b0);
    wait_cyc(3 * TD);
    check("release_state_idle", 32'(if_w.state), 32'(ST_IDLE));
    push(0, 10'b0010000000, ST_LEFT); press(0, 1'b1, 1'b0);
    check("second_press_leds", 32'(if_w.leds), 32'(10'b0010000000));
    push(0, 10'b0100000000, ST_LEFT); press(0, 1'b1, 1'b0);
    push(0, 10'b1000000000, ST_LEFT); press(0, 1'b1, 1'b0);
    push(0, 10'b0000000001, ST_LEFT); press(0, 1'b1, 1'b0);
    check("rotate_wrap_leds", 32'(if_w.leds), 32'(10'b0000000001));
    drain(0, 1, "rotate_q");

    // Saturate: walk to bit 0, then one more right press is a no-op
    push(1, 10'b0000010000, ST_RIGHT); press(1, 1'b0, 1'b1);
    push(1, 10'b0000001000, ST_RIGHT); press(1, 1'b0, 1'b1);
    push(1, 10'b0000000100, ST_RIGHT); press(1, 1'b0, 1'b1);
    push(1, 10'b0000000010, ST_RIGHT); press(1, 1'b0, 1'b1);
    push(1, 10'b0000000001, ST_RIGHT); press(1, 1'b0, 1'b1);
    set_pads(1, 1'b0, 1'b1);
    wait_cyc(4 * TD);
    check("sat_hold_state", 32'(if_s.state), 32'(ST_RIGHT));
    set_pads(1, 1'b0, 1'b0);
    wait_cyc(3 * TD);
    check("sat_leds", 32'(if_s.leds), 32'(10'b0000000001));
    push(1, 10'b0000000010, ST_LEFT); press(1, 1'b1, 1'b0);
    check("sat_left_leds", 32'(if_s.leds), 32'(10'b0000000010));

    // Clear, then spread, then direct switch to right
    if_w.clear = 1'b1;
    wait_cyc(1);
    if_w.clear = 1'b0;
    check("clear_leds", 32'(if_w.leds), 32'(c_RST));
    push(0, 10'b0001010000, ST_BOTH);
    set_pads(0, 1'b1, 1'b1);
    wait_cyc(4 * TD);
    check("both_state", 32'(if_w.state), 32'(ST_BOTH));
    push(0, 10'b0000101000, ST_RIGHT);
    set_pads(0, 1'b0, 1'b1);
    wait_cyc(4 * TD);
    set_pads(0, 1'b0, 1'b0);
    wait_cyc(3 * TD);
    check("both_right_leds", 32'(if_w.leds), 32'(10'b0000101000));

    // Repeat: steps at ticks 1, 4, 7 spaced REPEAT_TICKS*TICK_DIV cycles
    push(2, 10'b0000010000, ST_RIGHT);
    push(2, 10'b0000001000, ST_RIGHT);
    push(2, 10'b0000000100, ST_RIGHT);
    set_pads(2, 1'b0, 1'b1);
    drain(2, 60, "repeat_q");
    set_pads(2, 1'b0, 1'b0);
    wait_cyc(5 * TD);
    check("repeat_count", 32'(rep_n), 32'd3);
    check("repeat_gap1", 32'(rep_t[1] - rep_t[0]), 32'(3 * TD));
    check("repeat_gap2", 32'(rep_t[2] - rep_t[1]), 32'(3 * TD));

    // Clear landing on an action tick: clear wins, no step
    if_w.clear = 1'b1;
    wait_cyc(1);
    if_w.clear = 1'b0;
    set_pads(0, 1'b1, 1'b0);
    wait_cyc(3);
    if_w.clear = 1'b1;
    wait_cyc(1);
    if_w.clear = 1'b0;
    set_pads(0, 1'b0, 1'b0);
    check("clear_tick_leds", 32'(if_w.leds), 32'(c_RST));
    check("clear_tick_state", 32'(if_w.state), 32'(ST_IDLE));
    check("clear_tick_step", 32'(if_w.step_pulse), 32'd0);
    wait_cyc(4 * TD);
    check("clear_tick_after", 32'(if_w.leds), 32'(c_RST));

    // Asynchronous reset mid-hold; pad still held acts on first tick after
    push(2, 10'b0000001000, ST_LEFT);
    set_pads(2, 1'b1, 1'b0);
    drain(2, 30, "prereset_q");
    wait_cyc(5);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    wait_cyc(2);
    push(2, 10'b0001000000, ST_LEFT);
    rst_n = 1'b1;
    drain(2, 30, "postreset_q");
    set_pads(2, 1'b0, 1'b0);
    wait_cyc(4 * TD);
    check("postreset_leds", 32'(if_r.leds), 32'(10'b0001000000));

    check("final_q", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
